// File: rtl/pipe_chain.sv
// pipe_chain: self-timed valid/ready register chain with bubble collapsing and per-stage flush.
// Define PIPE_CHAIN_SKID_EN to add a 2-entry skid FIFO after the oldest stage, which breaks the out_ready->in_ready path.
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+3)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [DEPTH-1:0] flush,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] take;
  logic             take_last;
  logic             kill_acc;
  logic             take_acc;
  logic             accept;
  logic             handoff;
  logic [CW-1:0]    killed;

`ifdef PIPE_CHAIN_SKID_EN
  logic [1:0]       skid_cnt;
  logic [WIDTH-1:0] skid_d [2];
  logic             skid_pop;

  // Skid space depends only on registered occupancy, so out_ready never reaches the stage handshakes.
  assign take_last = ~skid_cnt[1];
  assign out_valid = (skid_cnt != 2'd0) & ~flush[DEPTH-1];
  assign out_data  = skid_d[0];
  assign skid_pop  = out_valid & out_ready;
  assign handoff   = skid_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid_cnt  <= 2'd0;
      skid_d[0] <= '0;
      skid_d[1] <= '0;
    end else if (flush[DEPTH-1]) begin
      skid_cnt <= 2'd0;
    end else begin
      skid_cnt <= skid_cnt + 2'(adv[DEPTH-1]) - 2'(skid_pop);
      if (skid_pop) begin
        if (skid_cnt[1])
          skid_d[0] <= skid_d[1];
        else if (adv[DEPTH-1])
          skid_d[0] <= d[DEPTH-1];
      end else if (adv[DEPTH-1]) begin
        if (skid_cnt == 2'd0)
          skid_d[0] <= d[DEPTH-1];
        else
          skid_d[1] <= d[DEPTH-1];
      end
    end
  end
`else
  assign take_last = out_ready;
  assign out_valid = v[DEPTH-1] & ~flush[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign handoff   = adv[DEPTH-1];
`endif

  // Walk from the oldest stage down: kill is a suffix-OR of flush, take ripples back from the output.
  always_comb begin
    kill_acc = 1'b0;
    take_acc = take_last;
    kill     = '0;
    adv      = '0;
    take     = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      kill_acc = kill_acc | flush[k];
      kill[k]  = kill_acc;
      adv[k]   = v[k] & take_acc & ~kill_acc;
      take[k]  = ~v[k] | adv[k];
      take_acc = take[k];
    end
  end

  assign in_ready = take[0] & ~(|flush);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++)
        d[k] <= '0;
    end else begin
      if (accept) begin
        v[0] <= 1'b1;
        d[0] <= in_data;
      end else if (adv[0] | kill[0]) begin
        v[0] <= 1'b0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k-1]) begin
          v[k] <= 1'b1;
          d[k] <= d[k-1];
        end else if (adv[k] | kill[k]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    killed = '0;
    for (int k = 0; k < DEPTH; k++)
      killed = killed + CW'(v[k] & kill[k]);
`ifdef PIPE_CHAIN_SKID_EN
    if (flush[DEPTH-1])
      killed = killed + CW'(skid_cnt);
`endif
  end

  // Occupancy is bounded by the storage, so this arithmetic cannot wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      count <= '0;
    else
      count <= count + CW'(accept) - CW'(handoff) - killed;
  end

  assign empty = (count == '0);

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed checks of pipe_chain (default build, DEPTH=4) for streaming, stalls, flushes and reset.
module tb_pipe_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+3);

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] flush = '0;
  logic [CW-1:0]    count;
  logic             empty;

  int vectors = 0;
  int miscompares = 0;
  int exp_count;

  pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush),
    .count(count),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [31:0] data, input logic ordy, input logic [DEPTH-1:0] fl);
    in_valid  = iv;
    in_data   = data;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'b0000);
    resetn = 1'b0;
    tick();
    tick();
    check_output("reset out_valid", 32'(out_valid), 32'd0);
    check_output("reset count", 32'(count), 32'd0);
    check_output("reset empty", 32'(empty), 32'd1);
    check_output("reset in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    tick();

    // Stream 1..8 with out_ready held high
    $display("[TB] stream");
    for (int i = 1; i <= 12; i++) begin
      apply_stimulus(i <= 8, 32'(i), 1'b1, 4'b0000);
      #1;
      check_output($sformatf("stream in_ready %0d", i), 32'(in_ready), 32'd1);
      tick();
      check_output($sformatf("stream out_valid %0d", i), 32'(out_valid), 32'(i >= 4 && i <= 11));
      if (i >= 4 && i <= 11)
        check_output($sformatf("stream out_data %0d", i), out_data, 32'(i - 3));
      exp_count = (i <= 8) ? ((i < 4) ? i : 4) : 12 - i;
      check_output($sformatf("stream count %0d", i), 32'(count), 32'(exp_count));
    end
    check_output("stream empty", 32'(empty), 32'd1);

    // Backpressure: fill A..D, then one consume cycle while E enters
    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 32'hA + 32'(i), 1'b0, 4'b0000);
      tick();
    end
    check_output("bp count full", 32'(count), 32'd4);
    check_output("bp out_data A", out_data, 32'hA);
    apply_stimulus(1'b1, 32'hE, 1'b0, 4'b0000);
    #1;
    check_output("bp in_ready stalled", 32'(in_ready), 32'd0);
    apply_stimulus(1'b1, 32'hE, 1'b1, 4'b0000);
    #1;
    check_output("bp in_ready comb", 32'(in_ready), 32'd1);
    tick();
    check_output("bp count after swap", 32'(count), 32'd4);
    check_output("bp out_data B", out_data, 32'hB);
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b0000);
    for (int j = 1; j <= 3; j++) begin
      tick();
      check_output($sformatf("bp drain %0d", j), out_data, 32'hB + 32'(j));
    end
    tick();
    check_output("bp drained out_valid", 32'(out_valid), 32'd0);
    check_output("bp drained empty", 32'(empty), 32'd1);

    // Bubble collapse: A, two idle cycles, then B against a stalled output
    $display("[TB] bubble collapse");
    apply_stimulus(1'b1, 32'h100, 1'b0, 4'b0000);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'b0000);
    tick();
    tick();
    apply_stimulus(1'b1, 32'h200, 1'b0, 4'b0000);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'b0000);
    tick();
    tick();
    check_output("bubble count", 32'(count), 32'd2);
    check_output("bubble out_data A", out_data, 32'h100);
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b0000);
    tick();
    check_output("bubble B adjacent valid", 32'(out_valid), 32'd1);
    check_output("bubble B adjacent data", out_data, 32'h200);
    check_output("bubble count after A", 32'(count), 32'd1);
    tick();
    check_output("bubble empty", 32'(empty), 32'd1);

    // Flush on an empty chain blocks acceptance
    apply_stimulus(1'b1, 32'h55, 1'b0, 4'b0001);
    #1;
    check_output("flush blocks in_ready", 32'(in_ready), 32'd0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'b0000);
    check_output("flush nothing accepted", 32'(count), 32'd0);

    // Partial flush of stages 0..1 on a full chain
    $display("[TB] partial flush");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 32'h30 + 32'(i), 1'b0, 4'b0000);
      tick();
    end
    apply_stimulus(1'b1, 32'h99, 1'b0, 4'b0010);
    #1;
    check_output("pflush in_ready", 32'(in_ready), 32'd0);
    check_output("pflush out_valid kept", 32'(out_valid), 32'd1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'b0000);
    check_output("pflush count", 32'(count), 32'd2);
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b0000);
    #1;
    check_output("pflush out A", out_data, 32'h30);
    tick();
    check_output("pflush out B", out_data, 32'h31);
    check_output("pflush B valid", 32'(out_valid), 32'd1);
    tick();
    check_output("pflush drained", 32'(out_valid), 32'd0);
    check_output("pflush count zero", 32'(count), 32'd0);

    // Multiple flush bits while the oldest stages keep moving
    $display("[TB] multi flush");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h40 + 32'(i), 1'b0, 4'b0000);
      tick();
    end
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'b0000);
    tick();
    check_output("mflush count", 32'(count), 32'd3);
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b0011);
    #1;
    check_output("mflush out_valid", 32'(out_valid), 32'd1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'b0000);
    check_output("mflush count after", 32'(count), 32'd1);
    check_output("mflush older moved", out_data, 32'h41);
    check_output("mflush older valid", 32'(out_valid), 32'd1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b0000);
    tick();
    check_output("mflush empty", 32'(empty), 32'd1);

    // Flush of the oldest stage in its output cycle
    $display("[TB] output flush");
    apply_stimulus(1'b1, 32'h50, 1'b1, 4'b0000);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b0000);
    tick();
    tick();
    tick();
    check_output("oflush pre valid", 32'(out_valid), 32'd1);
    check_output("oflush pre data", out_data, 32'h50);
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b1000);
    #1;
    check_output("oflush masked", 32'(out_valid), 32'd0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b0000);
    check_output("oflush count", 32'(count), 32'd0);
    check_output("oflush empty", 32'(empty), 32'd1);
    check_output("oflush out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while entries are held
    $display("[TB] reset mid-traffic");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h60 + 32'(i), 1'b0, 4'b0000);
      tick();
    end
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'b0000);
    tick();
    check_output("rst pre out_valid", 32'(out_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("rst async out_valid", 32'(out_valid), 32'd0);
    check_output("rst async count", 32'(count), 32'd0);
    check_output("rst async empty", 32'(empty), 32'd1);
    tick();
    #3;
    resetn = 1'b1;
    apply_stimulus(1'b1, 32'h70, 1'b1, 4'b0000);
    #1;
    check_output("rst release in_ready", 32'(in_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1, 4'b0000);
    tick();
    tick();
    check_output("rst X not yet", 32'(out_valid), 32'd0);
    tick();
    check_output("rst X valid", 32'(out_valid), 32'd1);
    check_output("rst X data", out_data, 32'h70);
    tick();
    check_output("rst final empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
